// File: rtl/rf_seq_ctrl.sv
// Register-file operand sequencer: loads A/B/cfg slots, launches the vector FU, recycles A/B.
// Optional FU watchdog is compiled in with `define RF_SEQ_FU_TIMEOUT_EN.
// State   | meaning
// LOAD    | accept operands, issue RF writes, wait for write acks
// FIRE    | one-cycle FU launch with RF read enabled
// EXEC    | hold RF read until the FU reports done (or the watchdog trips)
module rf_seq_ctrl #(
  parameter int WIDTH          = 16,
  parameter int NUM_INPUTS     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [WIDTH*NUM_INPUTS-1:0] a_data,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [WIDTH*NUM_INPUTS-1:0] b_data,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [WIDTH-1:0]            cfg_data,
  output logic                        rf_wen1,
  output logic                        rf_wen2,
  output logic                        rf_wen3,
  output logic [WIDTH*NUM_INPUTS-1:0] rf_wdata1,
  output logic [WIDTH*NUM_INPUTS-1:0] rf_wdata2,
  output logic [WIDTH-1:0]            rf_wdata3,
  input  logic                        rf_wr_ack1,
  input  logic                        rf_wr_ack2,
  input  logic                        rf_wr_ack3,
  output logic                        rf_ren,
  output logic                        fu_start,
  input  logic                        fu_done,
  output logic                        busy,
  output logic [15:0]                 op_count,
  output logic                        err_timeout
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_FIRE = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("rf_seq_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]                  r_state;
  logic                        r_a_ld, r_b_ld, r_cfg_ld;
  logic                        r_a_pend, r_b_pend, r_cfg_pend;
  logic                        r_a_ready, r_b_ready, r_cfg_ready;
  logic                        r_rf_wen1, r_rf_wen2, r_rf_wen3;
  logic [WIDTH*NUM_INPUTS-1:0] r_rf_wdata1, r_rf_wdata2;
  logic [WIDTH-1:0]            r_rf_wdata3;
  logic                        r_rf_ren, r_fu_start, r_busy;
  logic [15:0]                 r_op_count;

  logic       w_a_hs, w_b_hs, w_cfg_hs;
  logic       w_a_ld_nxt, w_b_ld_nxt, w_cfg_ld_nxt;
  logic       w_a_pend_nxt, w_b_pend_nxt, w_cfg_pend_nxt;
  logic [1:0] w_state_nxt;
  logic       w_done, w_tmo;

  // Ready is only ever high in LOAD, so a handshake implies LOAD.
  assign w_a_hs   = a_valid   & r_a_ready;
  assign w_b_hs   = b_valid   & r_b_ready;
  assign w_cfg_hs = cfg_valid & r_cfg_ready;

`ifdef RF_SEQ_FU_TIMEOUT_EN
  localparam int TCW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TCW-1:0] r_tcnt;
  logic           r_err_timeout;

  assign w_tmo = (r_state == S_EXEC) && !fu_done && (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_state_nxt == S_FIRE) r_tcnt <= '0;
      else if (r_state == S_EXEC) r_tcnt <= r_tcnt + 1'b1;
      if (w_tmo) r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_tmo       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    w_a_pend_nxt   = r_a_pend   | w_a_hs;
    w_b_pend_nxt   = r_b_pend   | w_b_hs;
    w_cfg_pend_nxt = r_cfg_pend | w_cfg_hs;
    w_a_ld_nxt     = r_a_ld;
    w_b_ld_nxt     = r_b_ld;
    w_cfg_ld_nxt   = r_cfg_ld;
    // Acks outside a pending slot are ignored.
    if (r_a_pend & rf_wr_ack1)   begin w_a_pend_nxt   = 1'b0; w_a_ld_nxt   = 1'b1; end
    if (r_b_pend & rf_wr_ack2)   begin w_b_pend_nxt   = 1'b0; w_b_ld_nxt   = 1'b1; end
    if (r_cfg_pend & rf_wr_ack3) begin w_cfg_pend_nxt = 1'b0; w_cfg_ld_nxt = 1'b1; end

    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_a_ld_nxt & w_b_ld_nxt & w_cfg_ld_nxt &
            !(w_a_pend_nxt | w_b_pend_nxt | w_cfg_pend_nxt))
          w_state_nxt = S_FIRE;
      end
      S_FIRE, S_EXEC: begin
        if (fu_done) begin
          w_done      = 1'b1;
          w_state_nxt = S_LOAD;
        end else if (w_tmo) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase

    // Config stays loaded across operations; only the operand slots recycle.
    if (w_done | w_tmo) begin
      w_a_ld_nxt = 1'b0;
      w_b_ld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_a_ld      <= 1'b0;
      r_b_ld      <= 1'b0;
      r_cfg_ld    <= 1'b0;
      r_a_pend    <= 1'b0;
      r_b_pend    <= 1'b0;
      r_cfg_pend  <= 1'b0;
      r_a_ready   <= 1'b0;
      r_b_ready   <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_rf_wen1   <= 1'b0;
      r_rf_wen2   <= 1'b0;
      r_rf_wen3   <= 1'b0;
      r_rf_wdata1 <= '0;
      r_rf_wdata2 <= '0;
      r_rf_wdata3 <= '0;
      r_rf_ren    <= 1'b0;
      r_fu_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a_ld      <= w_a_ld_nxt;
      r_b_ld      <= w_b_ld_nxt;
      r_cfg_ld    <= w_cfg_ld_nxt;
      r_a_pend    <= w_a_pend_nxt;
      r_b_pend    <= w_b_pend_nxt;
      r_cfg_pend  <= w_cfg_pend_nxt;
      r_a_ready   <= (w_state_nxt == S_LOAD) & !w_a_ld_nxt   & !w_a_pend_nxt;
      r_b_ready   <= (w_state_nxt == S_LOAD) & !w_b_ld_nxt   & !w_b_pend_nxt;
      r_cfg_ready <= (w_state_nxt == S_LOAD) & !w_cfg_ld_nxt & !w_cfg_pend_nxt;
      r_rf_wen1   <= w_a_hs;
      r_rf_wen2   <= w_b_hs;
      r_rf_wen3   <= w_cfg_hs;
      if (w_a_hs)   r_rf_wdata1 <= a_data;
      if (w_b_hs)   r_rf_wdata2 <= b_data;
      if (w_cfg_hs) r_rf_wdata3 <= cfg_data;
      r_rf_ren    <= (w_state_nxt != S_LOAD);
      r_fu_start  <= (w_state_nxt == S_FIRE);
      r_busy      <= (w_state_nxt != S_LOAD);
      if (w_done) r_op_count <= r_op_count + 16'd1;
    end
  end

  assign a_ready   = r_a_ready;
  assign b_ready   = r_b_ready;
  assign cfg_ready = r_cfg_ready;
  assign rf_wen1   = r_rf_wen1;
  assign rf_wen2   = r_rf_wen2;
  assign rf_wen3   = r_rf_wen3;
  assign rf_wdata1 = r_rf_wdata1;
  assign rf_wdata2 = r_rf_wdata2;
  assign rf_wdata3 = r_rf_wdata3;
  assign rf_ren    = r_rf_ren;
  assign fu_start  = r_fu_start;
  assign busy      = r_busy;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Bench for rf_seq_ctrl: directed operations with literal expectations, then randomized traffic
// checked every cycle against a slot/phase reference model.
module tb_rf_seq_ctrl;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int VW = W * N;
  localparam int TO = 20;
`ifdef RF_SEQ_FU_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid, cfg_valid;
  logic          a_ready, b_ready, cfg_ready;
  logic [VW-1:0] a_data, b_data;
  logic [W-1:0]  cfg_data;
  logic          rf_wen1, rf_wen2, rf_wen3;
  logic [VW-1:0] rf_wdata1, rf_wdata2;
  logic [W-1:0]  rf_wdata3;
  logic          rf_wr_ack1, rf_wr_ack2, rf_wr_ack3;
  logic          rf_ren, fu_start, fu_done, busy, err_timeout;
  logic [15:0]   op_count;

  always #5 clk = ~clk;

  rf_seq_ctrl #(.WIDTH(W), .NUM_INPUTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .rf_wen1(rf_wen1), .rf_wen2(rf_wen2), .rf_wen3(rf_wen3),
    .rf_wdata1(rf_wdata1), .rf_wdata2(rf_wdata2), .rf_wdata3(rf_wdata3),
    .rf_wr_ack1(rf_wr_ack1), .rf_wr_ack2(rf_wr_ack2), .rf_wr_ack3(rf_wr_ack3),
    .rf_ren(rf_ren), .fu_start(fu_start), .fu_done(fu_done),
    .busy(busy), .op_count(op_count), .err_timeout(err_timeout)
  );

  // Model: each slot is EMPTY(0) / PENDING(1) / LOADED(2); phase is LOAD(0) / FIRE(1) / EXEC(2).
  int            slot[3];
  int            phase;
  int            exec_cycles;
  logic          e_rdy[3];
  logic          e_wen[3];
  logic [VW-1:0] e_wd1, e_wd2;
  logic [W-1:0]  e_wd3;
  logic          e_ren, e_start, e_busy, e_err;
  logic [15:0]   e_opc;

  int ack_cd[3];
  int ack_dly_max = 1;
  bit rand_acks = 1'b0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic ack[3];
    logic vld[3];
    int   np;
    bit   fin;
    ack = '{rf_wr_ack1, rf_wr_ack2, rf_wr_ack3};
    vld = '{a_valid, b_valid, cfg_valid};
    if (reset) begin
      for (int k = 0; k < 3; k++) begin slot[k] = 0; e_rdy[k] = 0; e_wen[k] = 0; end
      phase = 0; exec_cycles = 0;
      e_wd1 = '0; e_wd2 = '0; e_wd3 = '0;
      e_ren = 0; e_start = 0; e_busy = 0; e_err = 0; e_opc = '0;
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (slot[k] == 1 && ack[k]) slot[k] = 2;
      e_wen[k] = vld[k] && e_rdy[k];
      if (e_wen[k]) slot[k] = 1;
    end
    if (e_wen[0]) e_wd1 = a_data;
    if (e_wen[1]) e_wd2 = b_data;
    if (e_wen[2]) e_wd3 = cfg_data;
    np  = phase;
    fin = 0;
    if (phase == 0) begin
      if (slot[0] == 2 && slot[1] == 2 && slot[2] == 2) np = 1;
    end else if (fu_done) begin
      fin = 1;
      e_opc = e_opc + 16'd1;
    end else if (TMO_EN && phase == 2 && exec_cycles + 1 == TO) begin
      fin = 1;
      e_err = 1;
    end else begin
      exec_cycles = (phase == 1) ? 0 : exec_cycles + 1;
      np = 2;
    end
    if (fin) begin
      np = 0;
      slot[0] = 0;
      slot[1] = 0;
    end
    phase   = np;
    e_start = (np == 1);
    e_ren   = (np != 0);
    e_busy  = (np != 0);
    for (int k = 0; k < 3; k++) e_rdy[k] = (np == 0) && (slot[k] == 0);
  endtask

  // Plays the register file's ack side, advances the model one cycle and compares every output.
  task automatic step();
    logic ack[3];
    for (int k = 0; k < 3; k++) begin
      ack[k] = 1'b0;
      if (ack_cd[k] > 0) begin
        ack_cd[k]--;
        if (ack_cd[k] == 0) ack[k] = 1'b1;
      end else if (rand_acks && slot[k] != 1 && $urandom_range(7) == 0) begin
        ack[k] = 1'b1;
      end
      if (e_wen[k]) ack_cd[k] = (ack_dly_max > 1) ? int'($urandom_range(ack_dly_max, 1)) : 1;
      if (reset) ack_cd[k] = 0;
    end
    rf_wr_ack1 = ack[0];
    rf_wr_ack2 = ack[1];
    rf_wr_ack3 = ack[2];
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("a_ready", 64'(a_ready), 64'(e_rdy[0]));
    chk("b_ready", 64'(b_ready), 64'(e_rdy[1]));
    chk("cfg_ready", 64'(cfg_ready), 64'(e_rdy[2]));
    chk("rf_wen1", 64'(rf_wen1), 64'(e_wen[0]));
    chk("rf_wen2", 64'(rf_wen2), 64'(e_wen[1]));
    chk("rf_wen3", 64'(rf_wen3), 64'(e_wen[2]));
    chk("rf_wdata1", rf_wdata1, e_wd1);
    chk("rf_wdata2", rf_wdata2, e_wd2);
    chk("rf_wdata3", 64'(rf_wdata3), 64'(e_wd3));
    chk("rf_ren", 64'(rf_ren), 64'(e_ren));
    chk("fu_start", 64'(fu_start), 64'(e_start));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("op_count", 64'(op_count), 64'(e_opc));
    chk("err_timeout", 64'(err_timeout), 64'(e_err));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin ack_cd[k] = 0; e_wen[k] = 0; e_rdy[k] = 0; slot[k] = 0; end
    reset = 1; a_valid = 0; b_valid = 0; cfg_valid = 0; fu_done = 0;
    a_data = '0; b_data = '0; cfg_data = '0;
    rf_wr_ack1 = 0; rf_wr_ack2 = 0; rf_wr_ack3 = 0;
    #1;
    steps(3);
    chk("reset_a_ready", 64'(a_ready), 64'd0);
    chk("reset_op_count", 64'(op_count), 64'd0);
    reset = 0;
    steps(10);
    chk("idle_a_ready", 64'(a_ready), 64'd1);
    chk("idle_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("idle_rf_ren", 64'(rf_ren), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Operation 1: all three slots in one cycle.
    a_data = 64'h0004_0003_0002_0001; b_data = 64'h0008_0007_0006_0005; cfg_data = 16'h00A5;
    a_valid = 1; b_valid = 1; cfg_valid = 1;
    step();
    a_valid = 0; b_valid = 0; cfg_valid = 0;
    chk("op1_wen_all", 64'({rf_wen1, rf_wen2, rf_wen3}), 64'b111);
    chk("op1_wdata1", rf_wdata1, 64'h0004_0003_0002_0001);
    chk("op1_wdata2", rf_wdata2, 64'h0008_0007_0006_0005);
    chk("op1_wdata3", 64'(rf_wdata3), 64'h00A5);
    steps(2);
    chk("op1_fu_start", 64'(fu_start), 64'd1);
    chk("op1_rf_ren", 64'(rf_ren), 64'd1);
    steps(2);
    chk("op1_exec_ren", 64'(rf_ren), 64'd1);
    fu_done = 1; step(); fu_done = 0;
    chk("op1_ren_drop", 64'(rf_ren), 64'd0);
    chk("op1_op_count", 64'(op_count), 64'd1);
    chk("op1_cfg_sticky", 64'(cfg_ready), 64'd0);

    // Operation 2: A and B only, A offered again during EXEC.
    a_data = 64'h1111_2222_3333_4444; b_data = 64'h5555_6666_7777_8888;
    a_valid = 1; b_valid = 1; step(); a_valid = 0; b_valid = 0;
    chk("op2_wen3_idle", 64'(rf_wen3), 64'd0);
    steps(2);
    chk("op2_fu_start", 64'(fu_start), 64'd1);
    a_data = 64'hCAFE_0000_BEEF_0001; a_valid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("exec_a_ready", 64'(a_ready), 64'd0);
      chk("exec_wen1", 64'(rf_wen1), 64'd0);
    end
    fu_done = 1; step(); fu_done = 0;
    chk("op2_op_count", 64'(op_count), 64'd2);
    chk("op2_a_ready", 64'(a_ready), 64'd1);
    step(); a_valid = 0;
    chk("late_a_wen1", 64'(rf_wen1), 64'd1);
    chk("late_a_wdata1", rf_wdata1, 64'hCAFE_0000_BEEF_0001);

    // Operation 3: fu_done in the FIRE cycle.
    b_valid = 1; step(); b_valid = 0;
    steps(2);
    chk("op3_fu_start", 64'(fu_start), 64'd1);
    fu_done = 1; step(); fu_done = 0;
    chk("op3_ren_one_cycle", 64'(rf_ren), 64'd0);
    chk("op3_busy", 64'(busy), 64'd0);
    chk("op3_op_count", 64'(op_count), 64'd3);

`ifdef RF_SEQ_FU_TIMEOUT_EN
    a_valid = 1; b_valid = 1; step(); a_valid = 0; b_valid = 0;
    steps(2);
    chk("tmo_fu_start", 64'(fu_start), 64'd1);
    steps(TO + 5);
    chk("tmo_err", 64'(err_timeout), 64'd1);
    chk("tmo_ren", 64'(rf_ren), 64'd0);
    chk("tmo_op_count", 64'(op_count), 64'd3);
    chk("tmo_a_ready", 64'(a_ready), 64'd1);
`else
    chk("no_tmo_err", 64'(err_timeout), 64'd0);
`endif

    // Randomized traffic with variable ack latency, stray acks and occasional resets.
    rand_acks = 1'b1;
    ack_dly_max = 3;
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(599) == 0);
      a_valid   = $urandom_range(1);
      b_valid   = $urandom_range(1);
      cfg_valid = $urandom_range(1);
      a_data    = {$urandom, $urandom};
      b_data    = {$urandom, $urandom};
      cfg_data  = W'($urandom);
      fu_done   = ($urandom_range(3) == 0);
      step();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
